serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial subtractor computing Q = A - B with final borrow Bo, LSB first, one bit per clock.
- Built around a single full-subtractor cell and a borrow flip-flop.
- Complements the adder cells: sits beside them in the arithmetic library as the subtract direction, sized for area over speed.
- Start/done handshake lets a controller or bench issue one operation at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous active-low reset (sampled on CLK rising edge)
- START  in  1  request; accepted only in IDLE
- A  in  WIDTH  minuend, sampled on the accepting cycle only
- B  in  WIDTH  subtrahend, sampled on the accepting cycle only
- BUSY  out  1  high while an operation is in progress (RUN)
- DONE  out  1  single-cycle pulse when Q/Bo update
- Q  out  WIDTH  difference A - B mod 2^WIDTH, registered
- Bo  out  1  final borrow, 1 iff A < B unsigned, registered

Behaviour:
- Reset (RST_N=0 at a clock edge) gives:
  - state IDLE; BUSY=0, DONE=0, Q=0, Bo=0
  - operand shift registers, borrow FF and bit counter all 0
- Reset has priority over every other input, including mid-RUN; the in-flight operation is discarded and Q/Bo read 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 latches A and B into shift registers, clears the borrow FF and counter, and goes to RUN.
  - Otherwise stays in IDLE.
- RUN: each cycle processes bit 0 of the shift registers with borrow-in br.
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into the result register MSB; the operand registers shift right by one.
  - The counter increments.
  - After exactly WIDTH RUN cycles, go to FIN.
- FIN (one cycle):
  - DONE=1.
  - Q loads the assembled result and Bo loads the final br.
  - Next state is IDLE.
- BUSY=1 exactly in RUN; BUSY=0 in IDLE and FIN.
- Latency: START accepted at edge k, then DONE=1 and new Q/Bo visible during cycle k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- START while in RUN or FIN is ignored; no queuing. A/B changes after acceptance have no effect.
- Q/Bo hold the previous result until the next FIN cycle; they never show partial results.
- Back-to-back: START held high continuously gives a new acceptance on the first IDLE cycle after each FIN.
- Arithmetic is unsigned modulo 2^WIDTH; Bo is the only overflow indication.
- Edge cases:
  - A=B gives Q=0, Bo=0.
  - A=0, B=2^WIDTH-1 gives Q=1, Bo=1.

Decomposition:
- Shared package: state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_FIN=2'd2; counter width constant CNT_W = clog2(WIDTH+1).
- One sub-module, full_sub: combinational single-bit full subtractor.
  - Inputs: A, B, Bi.
  - Outputs: D, Bo.
  - Instantiated once in the datapath; verified standalone over all 8 input combinations.

Test Plan:
- Reset, then START with A=200, B=55 (WIDTH=8) -> BUSY high for 8 cycles, DONE pulse on cycle 9 after acceptance, Q=145, Bo=0.
- A=5, B=10 -> Q=251, Bo=1. Then A=0, B=1 -> Q=255, Bo=1. Then A=170, B=170 -> Q=0, Bo=0.
- Keep START high throughout while changing A/B mid-RUN -> result uses the originally latched operands only. The next acceptance occurs on the first IDLE cycle after DONE, and DONE pulses are spaced exactly 10 cycles apart.
- Sequence:
  - complete A=9, B=4 (Q=5)
  - START A=100, B=1, then assert RST_N=0 on the 4th RUN cycle
  - required: next cycle BUSY=0, DONE=0, Q=0, Bo=0, with no DONE pulse afterwards
  - a new START A=7, B=3 then completes with Q=4
- full_sub unit check across all 8 (A, B, Bi) combinations -> D = A^B^Bi, Bo = (~A&B) | (~(A^B)&Bi).
- Random sweep of 1000 operand pairs against a reference model of (A-B) mod 256 and A<B -> all match, with DONE exactly once per accepted START.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, counter sizing
// and the single-bit full-subtractor equations.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    // Borrow out: a is smaller than b, or they are equal and a borrow is pending.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] Q;
    logic             Bo;

    modport master (
        output START, A, B,
        input  BUSY, DONE, Q, Bo
    );

    modport slave (
        input  START, A, B,
        output BUSY, DONE, Q, Bo
    );
endinterface

// File: rtl/serial_sub_full_sub.sv
// Combinational single-bit full subtractor: D = A - B - Bi, Bo = borrow out.
module full_sub
    import serial_sub_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Bi,
    output logic D,
    output logic Bo
);
    assign D  = fs_diff(A, B, Bi);
    assign Bo = fs_borrow(A, B, Bi);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor Q = A - B, LSB first, one bit per clock through a single
// full-subtractor cell; Q/Bo only change when a whole result is available.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    serial_sub_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] q_r;
    logic             bo_r;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;

    full_sub u_cell (
        .A  (a_sr[0]),
        .B  (b_sr[0]),
        .Bi (br),
        .D  (d_bit),
        .Bo (br_nxt)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.START) state_nxt = S_RUN;
            S_RUN:   if (last_bit)  state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: Q/Bo load on the last RUN edge so they appear together with DONE.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            q_r    <= '0;
            bo_r   <= 1'b0;
            br     <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        a_sr   <= bus.A;
                        b_sr   <= bus.B;
                        res_sr <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= br_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        q_r  <= {d_bit, res_sr[WIDTH-1:1]};
                        bo_r <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY = (state == S_RUN);
    assign bus.DONE = (state == S_FIN);
    assign bus.Q    = q_r;
    assign bus.Bo   = bo_r;

endmodule

// File: tb/tb_serial_sub.sv
// Randomised self-checking bench for serial_sub with a cycle-level reference
// model of the handshake and an arithmetic model of the result.
module tb_serial_sub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_total = 0;
    logic chk_en = 1'b0;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    logic fs_a, fs_b, fs_bi, fs_d, fs_bo;
    full_sub u_fs (
        .A  (fs_a),
        .B  (fs_b),
        .Bi (fs_bi),
        .D  (fs_d),
        .Bo (fs_bo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: cycles since acceptance, and the arithmetic result.
    int         since = -1;
    logic [W-1:0] pend_q = '0;
    logic       pend_bo = 1'b0;
    logic [W-1:0] m_q = '0;
    logic       m_bo = 1'b0;

    always @(posedge clk) begin
        int av, bv;
        cyc++;
        if (!rst_n) begin
            since = -1;
            m_q   = '0;
            m_bo  = 1'b0;
        end else if (since < 0) begin
            if (bus.START) begin
                av      = int'(bus.A);
                bv      = int'(bus.B);
                since   = 0;
                pend_q  = W'((av - bv + (1 << W)) % (1 << W));
                pend_bo = (av < bv);
            end
        end else if (since == W) begin
            since = -1;
        end else begin
            since++;
            if (since == W) begin
                m_q  = pend_q;
                m_bo = pend_bo;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.BUSY), 32'(since >= 0 && since < W));
            chk("done", 32'(bus.DONE), 32'(since == W));
            chk("q",    32'(bus.Q),    32'(m_q));
            chk("bo",   32'(bus.Bo),   32'(m_bo));
            if (bus.DONE) done_total++;
        end
    end

    // Runs one operation from an idle DUT; returns at posedge+1 with the DUT idle again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic bo,
                         output int lat, output int busy_n);
        logic got;
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk); #1;
        bus.START = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        got    = 1'b0;
        lat    = 0;
        busy_n = 0;
        q      = '0;
        bo     = 1'b0;
        for (int i = 0; i < W + 4 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.BUSY) busy_n++;
            if (bus.DONE) begin
                got = 1'b1;
                q   = bus.Q;
                bo  = bus.Bo;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE required DONE within %0d cycles", W + 4);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] q;
        logic         bo;
        int           lat, busy_n, d0, nd, diff;
        int           done_cyc[$];
        logic [W-1:0] first_q;
        logic         first_bo;
        logic         seen;

        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_q",    32'(bus.Q),    32'd0);
        chk("rst_bo",   32'(bus.Bo),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full_sub standalone over all input combinations
        for (int i = 0; i < 8; i++) begin
            int diffv;
            fs_a  = i[2];
            fs_b  = i[1];
            fs_bi = i[0];
            #1;
            diffv = int'(fs_a) - int'(fs_b) - int'(fs_bi);
            chk("fs_d",  32'(fs_d),  32'(diffv & 1));
            chk("fs_bo", 32'(fs_bo), 32'(diffv < 0));
        end

        do_op(8'd200, 8'd55, q, bo, lat, busy_n);
        chk("op200_55_q", 32'(q), 32'd145);
        chk("op200_55_bo", 32'(bo), 32'd0);
        chk("op200_55_latency", 32'(lat), 32'd9);
        chk("op200_55_busy_cycles", 32'(busy_n), 32'd8);

        do_op(8'd5, 8'd10, q, bo, lat, busy_n);
        chk("op5_10_q", 32'(q), 32'd251);
        chk("op5_10_bo", 32'(bo), 32'd1);
        do_op(8'd0, 8'd1, q, bo, lat, busy_n);
        chk("op0_1_q", 32'(q), 32'd255);
        chk("op0_1_bo", 32'(bo), 32'd1);
        do_op(8'd170, 8'd170, q, bo, lat, busy_n);
        chk("op170_170_q", 32'(q), 32'd0);
        chk("op170_170_bo", 32'(bo), 32'd0);
        do_op(8'd0, 8'd255, q, bo, lat, busy_n);
        chk("op0_255_q", 32'(q), 32'd1);
        chk("op0_255_bo", 32'(bo), 32'd1);

        // START held high, operands scrambled every cycle after the first acceptance
        bus.START = 1'b1;
        bus.A     = 8'd60;
        bus.B     = 8'd25;
        seen      = 1'b0;
        first_q   = '0;
        first_bo  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.DONE) begin
                done_cyc.push_back(cyc);
                if (!seen) begin
                    seen     = 1'b1;
                    first_q  = bus.Q;
                    first_bo = bus.Bo;
                end
            end
            @(posedge clk); #1;
            bus.A = W'($urandom);
            bus.B = W'($urandom);
        end
        bus.START = 1'b0;
        chk("b2b_first_q", 32'(first_q), 32'd35);
        chk("b2b_first_bo", 32'(first_bo), 32'd0);
        nd = done_cyc.size();
        chk("b2b_pulses_ge3", 32'(nd >= 3), 32'd1);
        for (int i = 1; i < nd; i++) begin
            d0   = done_cyc[i-1];
            diff = done_cyc[i] - d0;
            chk("b2b_done_spacing", 32'(diff), 32'(W + 2));
        end
        repeat (W + 3) @(posedge clk);
        #1;

        // Reset in the middle of an operation
        do_op(8'd9, 8'd4, q, bo, lat, busy_n);
        chk("op9_4_q", 32'(q), 32'd5);
        bus.START = 1'b1;
        bus.A     = 8'd100;
        bus.B     = 8'd1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("run4_busy", 32'(bus.BUSY), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.BUSY), 32'd0);
        chk("midrst_done", 32'(bus.DONE), 32'd0);
        chk("midrst_q",    32'(bus.Q),    32'd0);
        chk("midrst_bo",   32'(bus.Bo),   32'd0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.DONE) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        @(posedge clk); #1;
        do_op(8'd7, 8'd3, q, bo, lat, busy_n);
        chk("op7_3_q", 32'(q), 32'd4);
        chk("op7_3_bo", 32'(bo), 32'd0);

        // Random sweep
        d0 = done_total;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            int           ia, ib;
            ra = W'($urandom);
            rb = W'($urandom);
            ia = int'(ra);
            ib = int'(rb);
            do_op(ra, rb, q, bo, lat, busy_n);
            chk("rand_q",  32'(q),  32'((ia - ib + 256) % 256));
            chk("rand_bo", 32'(bo), 32'(ia < ib));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        chk("rand_done_count", 32'(done_total - d0), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
